rr_arbiter_4: RTL



---
 rtl/rr_arbiter_4.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-requester round-robin arbiter.
//
// Shares one resource between four clients. In IDLE the request vector is
// scanned starting at the round-robin pointer (ptr, ptr+1, ptr+2, ptr+3 mod 4)
// and the first set bit wins. The winner keeps the grant until it drops its
// request. No other client can preempt it. After a release the pointer moves
// to the client just after the winner, and one IDLE cycle always separates
// two grants.
//
// Optional feature: define ARB_TIMEOUT_EN to compile in a hold timeout. A
// grant then lasts at most MAX_HOLD cycles. When it is revoked, timeout pulses
// for one cycle. Without the macro, timeout is tied to 0 and no counter exists.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles with the timeout (1..2^CNT_W-1)
//   CNT_W     width of the hold counter
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[3:0]   level requests, one per client
//   gnt[3:0]   registered one-hot grant, zero when nothing is granted
//   gnt_id     encoded index of the granted client, holds when gnt_valid=0
//   gnt_valid  high exactly when gnt is non-zero
//   timeout    one-cycle pulse when a grant is revoked by the hold timeout
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_param
        $error("rr_arbiter_4: MAX_HOLD out of range for CNT_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       vld_q, vld_d;
    logic [1:0] win;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`endif

    // Rotated priority encoder: walk from the lowest priority position down
    // to ptr so the last hit (the one closest to ptr) wins.
    always_comb begin
        win = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[2'(i) + ptr_q]) begin
                win = 2'(i) + ptr_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        vld_d    = vld_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    gnt_d    = 4'b0001 << win;
                    gnt_id_d = win;
                    vld_d    = 1'b1;
                    state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else begin
                    gnt_d = 4'b0000;
                    vld_d = 1'b0;
                end
            end
            BUSY: begin
                if (!req[gnt_id_q]) begin
                    gnt_d   = 4'b0000;
                    vld_d   = 1'b0;
                    ptr_d   = gnt_id_q + 2'd1;
                    state_d = IDLE;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q == HOLD_LAST) begin
                        // Revoke: behaves like a release plus the timeout pulse.
                        gnt_d   = 4'b0000;
                        vld_d   = 1'b0;
                        ptr_d   = gnt_id_q + 2'd1;
                        state_d = IDLE;
                        to_d    = 1'b1;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            vld_q    <= vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = vld_q;

endmodule
